// File: rtl/transpad_spm_wbuf.sv
// Scratchpad write buffer: pairs snooped address beats with in-order data beats
// and drains scratchpad hits into the SRAM write port under ready backpressure.
module transpad_spm_wbuf #(
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          addr_vld,
  input  logic          hit,
  input  logic [AW-1:0] spaddr,
  input  logic          dvalid,
  input  logic [DW-1:0] ddata,
  input  logic          flush,
  input  logic          err_clr,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic          sram_rdy,
  output logic          stall,
  output logic          busy,
  output logic [1:0]    err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Payload storage carries no reset; validity is tracked by the counters only.
  logic          aq_hit_q  [DEPTH];
  logic [AW-1:0] aq_addr_q [DEPTH];
  logic [AW-1:0] wf_addr_q [DEPTH];
  logic [DW-1:0] wf_data_q [DEPTH];

  logic [PW-1:0] aq_wptr_q, aq_wptr_d, aq_rptr_q, aq_rptr_d;
  logic [CW-1:0] aq_cnt_q,  aq_cnt_d;
  logic [PW-1:0] wf_wptr_q, wf_wptr_d, wf_rptr_q, wf_rptr_d;
  logic [CW-1:0] wf_cnt_q,  wf_cnt_d;
  logic [1:0]    err_q,     err_d;

  logic aq_empty, aq_full, wf_full;
  logic aq_pop, aq_push, aq_drop, orphan;
  logic wf_req, wf_pop, wf_push, wf_drop;

  always_comb begin
    aq_empty = (aq_cnt_q == '0);
    aq_full  = (aq_cnt_q == CW'(DEPTH));
    wf_full  = (wf_cnt_q == CW'(DEPTH));

    // A flush cycle ignores every push, pop and error event.
    aq_pop  = dvalid && !aq_empty && !flush;
    orphan  = dvalid &&  aq_empty && !flush;
    aq_push = addr_vld && (!aq_full || aq_pop) && !flush;
    aq_drop = addr_vld &&  aq_full && !aq_pop  && !flush;

    wf_pop  = sram_we && sram_rdy && !flush;
    wf_req  = aq_pop && aq_hit_q[aq_rptr_q];
    wf_push = wf_req && (!wf_full || wf_pop);
    wf_drop = wf_req &&  wf_full && !wf_pop;

    err_d = (err_q & ~{2{err_clr}}) | {orphan, aq_drop | wf_drop};

    if (flush) begin
      aq_wptr_d = '0;
      aq_rptr_d = '0;
      aq_cnt_d  = '0;
      wf_wptr_d = '0;
      wf_rptr_d = '0;
      wf_cnt_d  = '0;
    end else begin
      aq_wptr_d = aq_push ? aq_wptr_q + 1'b1 : aq_wptr_q;
      aq_rptr_d = aq_pop  ? aq_rptr_q + 1'b1 : aq_rptr_q;
      aq_cnt_d  = aq_cnt_q + CW'(aq_push) - CW'(aq_pop);
      wf_wptr_d = wf_push ? wf_wptr_q + 1'b1 : wf_wptr_q;
      wf_rptr_d = wf_pop  ? wf_rptr_q + 1'b1 : wf_rptr_q;
      wf_cnt_d  = wf_cnt_q + CW'(wf_push) - CW'(wf_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aq_wptr_q <= '0;
      aq_rptr_q <= '0;
      aq_cnt_q  <= '0;
      wf_wptr_q <= '0;
      wf_rptr_q <= '0;
      wf_cnt_q  <= '0;
      err_q     <= '0;
    end else begin
      aq_wptr_q <= aq_wptr_d;
      aq_rptr_q <= aq_rptr_d;
      aq_cnt_q  <= aq_cnt_d;
      wf_wptr_q <= wf_wptr_d;
      wf_rptr_q <= wf_rptr_d;
      wf_cnt_q  <= wf_cnt_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (aq_push) begin
      aq_hit_q[aq_wptr_q]  <= hit;
      aq_addr_q[aq_wptr_q] <= spaddr;
    end
    if (wf_push) begin
      wf_addr_q[wf_wptr_q] <= aq_addr_q[aq_rptr_q];
      wf_data_q[wf_wptr_q] <= ddata;
    end
  end

  // Head is gated by sram_we so idle/reset outputs read as zero.
  always_comb begin
    sram_we    = (wf_cnt_q != '0);
    sram_addr  = sram_we ? wf_addr_q[wf_rptr_q] : '0;
    sram_wdata = sram_we ? wf_data_q[wf_rptr_q] : '0;
    stall      = aq_full || wf_full;
    busy       = (aq_cnt_q != '0) || (wf_cnt_q != '0);
    err        = err_q;
  end

endmodule

// File: tb/tb_transpad_spm_wbuf.sv
// Directed plus randomized bench for transpad_spm_wbuf against a queue-level reference model.
module tb_transpad_spm_wbuf;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst, addr_vld, hit, dvalid, flush, err_clr, sram_rdy;
  logic [AW-1:0] spaddr;
  logic [DW-1:0] ddata;
  logic          sram_we, stall, busy;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [1:0]    err;

  int n_checks = 0;
  int n_errors = 0;

  logic [AW:0]   aq_m  [$];
  logic [AW-1:0] wfa_m [$];
  logic [DW-1:0] wfd_m [$];
  logic [1:0]    err_m;

  transpad_spm_wbuf #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr_vld   (addr_vld),
    .hit        (hit),
    .spaddr     (spaddr),
    .dvalid     (dvalid),
    .ddata      (ddata),
    .flush      (flush),
    .err_clr    (err_clr),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdy   (sram_rdy),
    .stall      (stall),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: queues updated per edge from the rules (pops before pushes, sizes from pre-edge state).
  task automatic model_step();
    int         aqn, wfn;
    bit         aqpop, wfpop;
    logic [AW:0] head;
    logic [1:0] errn;
    if (rst) begin
      aq_m.delete(); wfa_m.delete(); wfd_m.delete();
      err_m = 2'b00;
    end else if (flush) begin
      aq_m.delete(); wfa_m.delete(); wfd_m.delete();
      if (err_clr) err_m = 2'b00;
    end else begin
      aqn   = aq_m.size();
      wfn   = wfa_m.size();
      errn  = err_clr ? 2'b00 : err_m;
      wfpop = (wfn > 0) && sram_rdy;
      aqpop = dvalid && (aqn > 0);
      if (dvalid && aqn == 0) errn[1] = 1'b1;
      if (wfpop) begin
        void'(wfa_m.pop_front());
        void'(wfd_m.pop_front());
      end
      if (aqpop) begin
        head = aq_m.pop_front();
        if (head[AW]) begin
          if (wfn < DEPTH || wfpop) begin
            wfa_m.push_back(head[AW-1:0]);
            wfd_m.push_back(ddata);
          end else errn[0] = 1'b1;
        end
      end
      if (addr_vld) begin
        if (aqn < DEPTH || aqpop) aq_m.push_back({hit, spaddr});
        else errn[0] = 1'b1;
      end
      err_m = errn;
    end
  endtask

  task automatic check_outputs();
    bit we_m;
    we_m = wfa_m.size() > 0;
    check("sram_we",    64'(sram_we),    64'(we_m));
    check("sram_addr",  64'(sram_addr),  we_m ? 64'(wfa_m[0]) : 64'd0);
    check("sram_wdata", sram_wdata,      we_m ? wfd_m[0] : 64'd0);
    check("stall",      64'(stall),      64'(aq_m.size() == DEPTH || wfa_m.size() == DEPTH));
    check("busy",       64'(busy),       64'(aq_m.size() > 0 || wfa_m.size() > 0));
    check("err",        64'(err),        64'(err_m));
  endtask

  // Drive at negedge, let the edge happen, update model, check at next negedge.
  task automatic cycle(input logic av, input logic h, input logic [AW-1:0] sa,
                       input logic dv, input logic [DW-1:0] dd, input logic rdy,
                       input logic fl, input logic ec, input logic r);
    addr_vld = av; hit = h; spaddr = sa; dvalid = dv; ddata = dd;
    sram_rdy = rdy; flush = fl; err_clr = ec; rst = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic addr_beat(input logic h, input logic [AW-1:0] sa, input logic rdy);
    cycle(1'b1, h, sa, 1'b0, '0, rdy, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic data_beat(input logic [DW-1:0] dd, input logic rdy);
    cycle(1'b0, 1'b0, '0, 1'b1, dd, rdy, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 1'b0, '0, 1'b0, '0, rdy, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    addr_vld = 0; hit = 0; spaddr = '0; dvalid = 0; ddata = '0;
    sram_rdy = 0; flush = 0; err_clr = 0; rst = 1;
    err_m = 2'b00;
    @(negedge clk);
    cycle(0, 0, '0, 0, '0, 0, 0, 0, 1);
    cycle(0, 0, '0, 0, '0, 0, 0, 0, 1);
    check("reset_we", 64'(sram_we), 64'd0);
    check("reset_err", 64'(err), 64'd0);

    // Single hit pair, one-cycle latency to sram_we.
    addr_beat(1, 16'h0010, 1);
    check("t1_we_early", 64'(sram_we), 64'd0);
    data_beat(64'hA5A5, 1);
    check("t1_we",   64'(sram_we),  64'd1);
    check("t1_addr", 64'(sram_addr), 64'h0010);
    check("t1_data", sram_wdata,     64'hA5A5);
    idle(1);
    check("t1_busy", 64'(busy), 64'd0);

    // Mixed hits: only idx 5 and 7 are written.
    addr_beat(1, 16'd5, 0); addr_beat(0, 16'd6, 0); addr_beat(1, 16'd7, 0);
    data_beat(64'hD0, 0); data_beat(64'hD1, 0); data_beat(64'hD2, 0);
    check("t2_addr0", 64'(sram_addr), 64'd5);
    check("t2_data0", sram_wdata,     64'hD0);
    idle(1);
    check("t2_addr1", 64'(sram_addr), 64'd7);
    check("t2_data1", sram_wdata,     64'hD2);
    idle(1);
    check("t2_busy", 64'(busy), 64'd0);
    check("t2_err",  64'(err),  64'd0);

    // WF overflow under backpressure.
    for (int unsigned i = 0; i < 4; i++) begin
      addr_beat(1, 16'(16'h100 + i), 0);
      data_beat(64'(64'hB000 + i), 0);
    end
    check("t3_stall", 64'(stall), 64'd1);
    addr_beat(1, 16'h1FF, 0);
    data_beat(64'hBEEF, 0);
    check("t3_err", 64'(err), 64'd1);
    for (int unsigned i = 0; i < 4; i++) begin
      check("t3_order", 64'(sram_addr), 64'(16'h100 + i));
      idle(1);
    end
    check("t3_busy", 64'(busy), 64'd0);
    cycle(0, 0, '0, 0, '0, 1, 0, 1, 0);
    check("t3_clr", 64'(err), 64'd0);

    // Orphan data beat.
    data_beat(64'h1234, 1);
    check("t4_err", 64'(err), 64'd2);
    check("t4_we",  64'(sram_we), 64'd0);
    cycle(0, 0, '0, 0, '0, 1, 0, 1, 0);
    check("t4_clr", 64'(err), 64'd0);

    // AQ full with simultaneous push/pop: no drop.
    for (int unsigned i = 0; i < 4; i++) addr_beat(0, 16'(i), 1);
    check("t5_stall", 64'(stall), 64'd1);
    cycle(1, 0, 16'h55, 1, 64'h77, 1, 0, 0, 0);
    check("t5_err",   64'(err),   64'd0);
    check("t5_stall2", 64'(stall), 64'd1);
    for (int unsigned i = 0; i < 4; i++) data_beat(64'(i), 1);
    check("t5_busy", 64'(busy), 64'd0);

    // Flush keeps err; reset mid-drain clears everything.
    data_beat(64'h0, 0);
    for (int unsigned i = 0; i < 2; i++) begin
      addr_beat(1, 16'(16'h200 + i), 0);
      data_beat(64'(64'hC000 + i), 0);
    end
    cycle(0, 0, '0, 0, '0, 0, 1, 0, 0);
    check("t6_we",   64'(sram_we), 64'd0);
    check("t6_busy", 64'(busy),    64'd0);
    check("t6_err",  64'(err),     64'd2);
    for (int unsigned i = 0; i < 3; i++) begin
      addr_beat(1, 16'(16'h300 + i), 0);
      data_beat(64'(64'hE000 + i), 0);
    end
    idle(1);
    cycle(0, 0, '0, 0, '0, 1, 0, 0, 1);
    check("t6_rst_we",   64'(sram_we),    64'd0);
    check("t6_rst_addr", 64'(sram_addr),  64'd0);
    check("t6_rst_data", sram_wdata,      64'd0);
    check("t6_rst_err",  64'(err),        64'd0);

    // Randomized traffic.
    for (int unsigned n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 99) < 50,
            $urandom_range(0, 99) < 70,
            AW'($urandom),
            $urandom_range(0, 99) < 45,
            {$urandom, $urandom},
            $urandom_range(0, 99) < 55,
            $urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < 4,
            $urandom_range(0, 999) < 5);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
